mem_port_arbiter: RTL and testbench

Arbitrates the single-port feature/weight memory of the CNN convolution engine among three burst requesters: result write-back (WB), filter-buffer load (FL) and input-window/temp-buffer load (TL). A granted requester owns the port for one contiguous burst. The arbiter generates the memory address, read enable and write enable for every beat, and returns read data with a per-requester valid strobe. It sits between the main convolution controller's load/store phases and the memory.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - burst arbiter for the CNN engine's single-port feature/weight memory
//
// Three burst requesters share one memory port:
//   WB (result write-back, writes), FL (filter-buffer load, reads), TL (input-window/temp-buffer load, reads).
// A winner owns the port for len+1 contiguous beats, then one DRAIN cycle lets the last
// read word come back before the next IDLE sample.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - round-robin search starting after the last granted requester (WB->FL->TL->WB)
//   undefined - fixed priority WB > FL > TL, no pointer register
//
// Ports:
//   clk, rstN                 clock (rising edge), asynchronous active-low reset
//   reqWB/reqFL/reqTL         burst requests, held until the matching gnt
//   adrWB/adrFL/adrTL         burst start addresses, valid with req
//   lenWB/lenFL/lenTL         beats minus one, valid with req
//   wbData                    write-back data for the current beat
//   gntWB/gntFL/gntTL         one-cycle pulse on a burst's first beat
//   wbAck                     WB beat written this cycle
//   rdValidFL/rdValidTL       rdData carries a beat for that requester
//   rdData                    shared read data (memRdata pass-through)
//   memAdr, memRe, memWe      memory address and enables (registered)
//   memWdata                  memory write data (wbData pass-through)
//   memRdata                  memory read data, one cycle after memRe
//   busy                      arbiter is not idle
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqWB,
  input  logic              reqFL,
  input  logic              reqTL,
  input  logic [ADDR_W-1:0] adrWB,
  input  logic [ADDR_W-1:0] adrFL,
  input  logic [ADDR_W-1:0] adrTL,
  input  logic [LEN_W-1:0]  lenWB,
  input  logic [LEN_W-1:0]  lenFL,
  input  logic [LEN_W-1:0]  lenTL,
  input  logic [DATA_W-1:0] wbData,
  output logic              gntWB,
  output logic              gntFL,
  output logic              gntTL,
  output logic              wbAck,
  output logic              rdValidFL,
  output logic              rdValidTL,
  output logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] memAdr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] ID_WB = 2'd0;
  localparam logic [1:0] ID_FL = 2'd1;
  localparam logic [1:0] ID_TL = 2'd2;

  state_t            state;
  logic [LEN_W-1:0]  beatCnt;
  logic [LEN_W-1:0]  curLen;
  logic [1:0]        owner;
  logic [1:0]        winner;
  logic              anyReq;

`ifdef ARB_ROUND_ROBIN_EN
  // Points at the requester that is searched first at the next IDLE sample.
  logic [1:0]        rrPtr;
`endif

  assign rdData   = memRdata;
  assign memWdata = wbData;
  assign anyReq   = reqWB | reqFL | reqTL;

  // Winner is only meaningful when anyReq is high.
  always_comb begin
    winner = ID_WB;
`ifdef ARB_ROUND_ROBIN_EN
    case (rrPtr)
      ID_FL: begin
        if (reqFL)      winner = ID_FL;
        else if (reqTL) winner = ID_TL;
        else            winner = ID_WB;
      end
      ID_TL: begin
        if (reqTL)      winner = ID_TL;
        else if (reqWB) winner = ID_WB;
        else            winner = ID_FL;
      end
      default: begin
        if (reqWB)      winner = ID_WB;
        else if (reqFL) winner = ID_FL;
        else            winner = ID_TL;
      end
    endcase
`else
    if (reqWB)      winner = ID_WB;
    else if (reqFL) winner = ID_FL;
    else            winner = ID_TL;
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      gntWB     <= 1'b0;
      gntFL     <= 1'b0;
      gntTL     <= 1'b0;
      wbAck     <= 1'b0;
      rdValidFL <= 1'b0;
      rdValidTL <= 1'b0;
      memRe     <= 1'b0;
      memWe     <= 1'b0;
      busy      <= 1'b0;
      memAdr    <= '0;
      beatCnt   <= '0;
      curLen    <= '0;
      owner     <= ID_WB;
`ifdef ARB_ROUND_ROBIN_EN
      rrPtr     <= ID_WB;
`endif
    end else begin
      gntWB <= 1'b0;
      gntFL <= 1'b0;
      gntTL <= 1'b0;
      // Read data returns one cycle after memRe; owner is stable through DRAIN,
      // so the last beat's valid lands in the DRAIN cycle.
      rdValidFL <= memRe && (owner == ID_FL);
      rdValidTL <= memRe && (owner == ID_TL);

      case (state)
        IDLE: begin
          if (anyReq) begin
            state   <= BURST;
            busy    <= 1'b1;
            owner   <= winner;
            beatCnt <= '0;
            case (winner)
              ID_WB: begin
                gntWB  <= 1'b1;
                memAdr <= adrWB;
                curLen <= lenWB;
                memWe  <= 1'b1;
                wbAck  <= 1'b1;
              end
              ID_FL: begin
                gntFL  <= 1'b1;
                memAdr <= adrFL;
                curLen <= lenFL;
                memRe  <= 1'b1;
              end
              default: begin
                gntTL  <= 1'b1;
                memAdr <= adrTL;
                curLen <= lenTL;
                memRe  <= 1'b1;
              end
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            rrPtr <= (winner == ID_TL) ? ID_WB : winner + 2'd1;
`endif
          end
        end
        BURST: begin
          if (beatCnt == curLen) begin
            state <= DRAIN;
            memRe <= 1'b0;
            memWe <= 1'b0;
            wbAck <= 1'b0;
          end else begin
            beatCnt <= beatCnt + LEN_W'(1);
            memAdr  <= memAdr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          memRe <= 1'b0;
          memWe <= 1'b0;
          wbAck <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqWB, reqFL, reqTL;
  logic [15:0] adrWB, adrFL, adrTL;
  logic [3:0]  lenWB, lenFL, lenTL;
  logic [15:0] wbData;
  logic        gntWB, gntFL, gntTL, wbAck, rdValidFL, rdValidTL;
  logic [15:0] rdData, memAdr, memWdata;
  logic [15:0] memRdata = 16'h0;
  logic        memRe, memWe, busy;

  mem_port_arbiter dut (
    .clk(clk), .rstN(rstN),
    .reqWB(reqWB), .reqFL(reqFL), .reqTL(reqTL),
    .adrWB(adrWB), .adrFL(adrFL), .adrTL(adrTL),
    .lenWB(lenWB), .lenFL(lenFL), .lenTL(lenTL),
    .wbData(wbData),
    .gntWB(gntWB), .gntFL(gntFL), .gntTL(gntTL),
    .wbAck(wbAck), .rdValidFL(rdValidFL), .rdValidTL(rdValidTL),
    .rdData(rdData), .memAdr(memAdr), .memRe(memRe), .memWe(memWe),
    .memWdata(memWdata), .memRdata(memRdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Synchronous memory: data for the address presented with memRe appears next cycle.
  always @(posedge clk) if (memRe === 1'b1) memRdata <= memFn(memAdr);

  // Expected per-cycle control vector:
  // {gntWB,gntFL,gntTL,wbAck,rdValidFL,rdValidTL,memRe,memWe,busy}
  logic [8:0]  expSig [NCYC];
  logic [15:0] expAdr [NCYC];
  logic [15:0] expWd  [NCYC];
  logic [15:0] expRd  [NCYC];
  bit          expAdrV[NCYC];
  bit          expWdV [NCYC];
  bit          expRdV [NCYC];

  bit          reqV [3];
  logic [15:0] adrV [3];
  logic [3:0]  lenV [3];
  logic [15:0] words[16];
  bit          presetWords;
  bit          randOn;
  int          wbPtr;
  int          freeAt;
  int          rrPtr;
  int          cyc;
  int          vectors;
  int          miscompares;
  int          gotG[$];
  int          gotC[$];

  task automatic clearFrom(input int first);
    for (int c = first; c < NCYC; c++) begin
      expSig[c] = '0; expAdr[c] = '0; expWd[c] = '0; expRd[c] = '0;
      expAdrV[c] = 0; expWdV[c] = 0; expRdV[c] = 0;
    end
  endtask

  // Lays out a whole burst on the timeline from its decision cycle n.
  task automatic schedule(input int i, input int n);
    logic [15:0] a;
    int          L;
    L = int'(lenV[i]);
    expSig[n+1][8-i] = 1'b1;
    for (int k = 0; k <= L; k++) begin
      a = adrV[i] + 16'(k);
      expAdr[n+1+k] = a;
      expAdrV[n+1+k] = 1;
      if (i == 0) begin
        expSig[n+1+k][5] = 1'b1;
        expSig[n+1+k][1] = 1'b1;
        expWd[n+1+k] = words[k];
        expWdV[n+1+k] = 1;
      end else begin
        expSig[n+1+k][2] = 1'b1;
        expSig[n+2+k][(i == 1) ? 4 : 3] = 1'b1;
        expRd[n+2+k] = memFn(a);
        expRdV[n+2+k] = 1;
      end
    end
    for (int b = n + 1; b <= n + 2 + L; b++) expSig[b][0] = 1'b1;
    freeAt = n + 3 + L;
  endtask

  task automatic decide(input int c);
    int w;
    w = -1;
    if (rstN !== 1'b1 || c < freeAt) return;
`ifdef ARB_ROUND_ROBIN_EN
    for (int j = 0; j < 3; j++) if (w < 0 && reqV[(rrPtr + j) % 3]) w = (rrPtr + j) % 3;
`else
    for (int j = 0; j < 3; j++) if (w < 0 && reqV[j]) w = j;
`endif
    if (w < 0) return;
    if (w == 0) begin
      if (!presetWords) for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      presetWords = 0;
      wbPtr = 0;
    end
    schedule(w, c);
    reqV[w] = 0;
    rrPtr = (w + 1) % 3;
  endtask

  task automatic drive();
    reqWB = reqV[0]; reqFL = reqV[1]; reqTL = reqV[2];
    adrWB = adrV[0]; adrFL = adrV[1]; adrTL = adrV[2];
    lenWB = lenV[0]; lenFL = lenV[1]; lenTL = lenV[2];
    wbData = words[wbPtr];
  endtask

  task automatic randReq();
    for (int i = 0; i < 3; i++) begin
      if (!reqV[i] && $urandom_range(0, 99) < 30) begin
        reqV[i] = 1;
        adrV[i] = 16'($urandom);
        lenV[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end else if (reqV[i] && $urandom_range(0, 99) < 3) begin
        reqV[i] = 0;
      end
    end
  endtask

  task automatic check(input int c);
    logic [8:0] got;
    got = {gntWB, gntFL, gntTL, wbAck, rdValidFL, rdValidTL, memRe, memWe, busy};
    vectors++;
    assert (got === expSig[c]) else begin
      miscompares++;
      $error("FAIL ctl cyc=%0d observed=%b expected=%b", c, got, expSig[c]);
    end
    if (expAdrV[c]) begin
      vectors++;
      assert (memAdr === expAdr[c]) else begin
        miscompares++;
        $error("FAIL memAdr cyc=%0d observed=%h expected=%h", c, memAdr, expAdr[c]);
      end
    end
    if (expWdV[c]) begin
      vectors++;
      assert (memWdata === expWd[c]) else begin
        miscompares++;
        $error("FAIL memWdata cyc=%0d observed=%h expected=%h", c, memWdata, expWd[c]);
      end
    end
    if (expRdV[c]) begin
      vectors++;
      assert (rdData === expRd[c]) else begin
        miscompares++;
        $error("FAIL rdData cyc=%0d observed=%h expected=%h", c, rdData, expRd[c]);
      end
    end
    if (rstN === 1'b0) begin
      vectors++;
      assert (memAdr === 16'h0) else begin
        miscompares++;
        $error("FAIL rstAdr cyc=%0d observed=%h expected=0000", c, memAdr);
      end
    end
    if (gntWB === 1'b1) begin gotG.push_back(0); gotC.push_back(c); end
    if (gntFL === 1'b1) begin gotG.push_back(1); gotC.push_back(c); end
    if (gntTL === 1'b1) begin gotG.push_back(2); gotC.push_back(c); end
  endtask

  task automatic step();
    @(negedge clk);
    check(cyc);
    if (wbAck === 1'b1 && wbPtr < 15) wbPtr++;
    decide(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (randOn) randReq();
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic setReq(input int i, input logic [15:0] a, input logic [3:0] l);
    reqV[i] = 1; adrV[i] = a; lenV[i] = l;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; wbPtr = 0; rrPtr = 0;
    freeAt = NCYC; presetWords = 0; randOn = 0;
    clearFrom(0);
    for (int i = 0; i < 3; i++) begin reqV[i] = 0; adrV[i] = '0; lenV[i] = '0; end
    for (int k = 0; k < 16; k++) words[k] = '0;
    rstN = 1'b0;
    drive();
    steps(3);
    rstN = 1'b1;
    freeAt = cyc;
    steps(2);

    // FL read burst of 4 beats
    setReq(1, 16'h0010, 4'd3); drive();
    steps(12);

    // WB write burst, two fixed words
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; presetWords = 1;
    setReq(0, 16'h0200, 4'd1); drive();
    steps(10);

    // Three simultaneous single-beat requests
    gotG.delete(); gotC.delete();
    setReq(0, 16'h0300, 4'd0); setReq(1, 16'h0400, 4'd0); setReq(2, 16'h0500, 4'd0); drive();
    steps(14);
`ifndef ARB_ROUND_ROBIN_EN
    vectors++;
    assert (gotG.size() == 3 && gotG[0] == 0 && gotG[1] == 1 && gotG[2] == 2) else begin
      miscompares++;
      $error("FAIL prioOrder observed=%p expected=WB,FL,TL", gotG);
    end
    vectors++;
    assert (gotC.size() == 3 && gotC[1] - gotC[0] == 3 && gotC[2] - gotC[1] == 3) else begin
      miscompares++;
      $error("FAIL prioSpacing observed=%p expected=3-cycle spacing", gotC);
    end
`endif

    // TL read across the top of the address space
    setReq(2, 16'hFFFE, 4'd2); drive();
    steps(10);

    // Reset during beat 1 of a long FL burst
    setReq(1, 16'h0800, 4'd7); drive();
    steps(2);
    #1 rstN = 1'b0;
    #1;
    vectors++;
    assert ({gntWB, gntFL, gntTL, wbAck, rdValidFL, rdValidTL, memRe, memWe, busy} === 9'b0
            && memAdr === 16'h0) else begin
      miscompares++;
      $error("FAIL midRst observed=%b/%h expected=0/0000",
             {gntWB, gntFL, gntTL, wbAck, rdValidFL, rdValidTL, memRe, memWe, busy}, memAdr);
    end
    clearFrom(cyc);
    freeAt = NCYC;
    rrPtr = 0;
    for (int i = 0; i < 3; i++) reqV[i] = 0;
    drive();
    steps(3);
    rstN = 1'b1;
    freeAt = cyc;
    setReq(2, 16'h1234, 4'd1); drive();
    steps(8);

    // Random traffic
    randOn = 1;
    steps(1500);
    randOn = 0;
    for (int i = 0; i < 3; i++) reqV[i] = 0;
    drive();
    steps(45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
